// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the execute-stage multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Iteration counter width for a given operand width.
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier
//  Description : Iterative shift-add multiplier, signed or unsigned, producing
//                a 2*width product after exactly width RUN cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier
  import cpu_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [width-1:0] op_a,
  input  logic [width-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] product_hi,
  output logic [width-1:0] product_lo
);

  localparam int            CW       = cnt_width(width);
  localparam int            PW       = 2 * width;
  localparam logic [CW-1:0] CNT_LAST = CW'(width - 1);

  mul_state_t    state_q,  state_d;
  logic [PW-1:0] mcand_q,  mcand_d;   // multiplicand, shifted left each step
  logic [width-1:0] mplier_q, mplier_d; // multiplier, shifted right each step
  logic [PW-1:0] acc_q,    acc_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          neg_q,    neg_d;
  logic [PW-1:0] prod_q,   prod_d;

  logic [width-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc_next, acc_final;

  // Operand magnitudes; the most-negative value maps onto 2^(width-1) unsigned.
  always_comb begin
    a_mag = (signed_op && op_a[width-1]) ? (~op_a + width'(1)) : op_a;
    b_mag = (signed_op && op_b[width-1]) ? (~op_b + width'(1)) : op_b;
  end

  // Partial-product accumulate and final sign restoration.
  always_comb begin
    acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    acc_final = neg_q ? (~acc_next + PW'(1)) : acc_next;
  end

  // Next-state and datapath update; every register holds by default.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    prod_d   = prod_q;
    case (state_q)
      RUN: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          prod_d  = acc_final;
          state_d = DONE;
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          mcand_d  = {{width{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = signed_op & (op_a[width-1] ^ op_b[width-1]);
          state_d  = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign product_hi = prod_q[PW-1:width];
  assign product_lo = prod_q[width-1:0];

endmodule : seq_multiplier
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_multiplier
//  Description : Scoreboard bench for seq_multiplier with a 64-bit arithmetic
//                reference and a cycle-level acceptance/latency model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done;
  logic [W-1:0] product_hi, product_lo;

  seq_multiplier #(.width(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .signed_op  (signed_op),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product_hi (product_hi),
    .product_lo (product_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          k0 = 0;
  bit          have = 1'b0;
  logic [63:0] held = '0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    longint sa, sbv;
    if (s) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      return 64'(sa * sbv);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Drive one start pulse from the current negedge; the model decides acceptance.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    op_a = a; op_b = b; signed_op = s; start = 1'b1;
    if (!(have && cyc >= k0 + 1 && cyc <= k0 + W)) begin
      e.prod = ref_mul(a, b, s);
      e.due  = cyc + W + 1;
      sb.push_back(e);
      have = 1'b1;
      k0   = cyc;
    end
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; signed_op = 1'($urandom);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset_mid;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", {product_hi, product_lo}, 0);
    sb.delete();
    have = 1'b0;
    held = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: checks handshake timing every cycle and pops the scoreboard on done.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      chk("busy", busy, (have && cyc >= k0 + 1 && cyc <= k0 + W) ? 1 : 0);
      chk("done", done, (have && cyc == k0 + W + 1) ? 1 : 0);
      if (done) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got done=1 expected no pending result (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("product", {product_hi, product_lo}, e.prod);
          chk("latency", 64'(cyc), 64'(e.due));
          held = e.prod;
        end
      end else begin
        chk("hold", {product_hi, product_lo}, held);
      end
    end
  end

  initial begin
    #2;
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_product", {product_hi, product_lo}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'd7, 32'd6, 1'b0);                    wait_until(k0 + W + 3);
    issue(32'hFFFF_FFFD, 32'd5, 1'b1);            wait_until(k0 + W + 3);
    issue(32'hFFFF_FFFD, 32'd5, 1'b0);            wait_until(k0 + W + 3);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);    wait_until(k0 + W + 3);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1);    wait_until(k0 + W + 3);
    issue(32'h8000_0000, 32'd1, 1'b1);            wait_until(k0 + W + 3);
    issue(32'd0, 32'd12345, 1'b0);                wait_until(k0 + W + 3);

    // start while busy is ignored
    issue(32'd100, 32'd200, 1'b0);
    wait_until(k0 + 10);
    issue(32'd5, 32'd5, 1'b1);
    wait_until(k0 + W + 3);

    // back-to-back: restart in the done cycle
    issue(32'd123456, 32'd789, 1'b0);
    wait_until(k0 + W + 1);
    issue(32'd9, 32'd9, 1'b0);
    wait_until(k0 + W + 3);

    // reset mid-operation, then a fresh multiply
    issue(32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
    wait_until(k0 + 15);
    do_reset_mid();
    repeat (W + 5) @(negedge clk);
    issue(32'd2, 32'd3, 1'b0);
    wait_until(k0 + W + 3);

    // randomized traffic, some starts landing while busy
    for (int i = 0; i < 40; i++) begin
      issue($urandom, $urandom, 1'($urandom));
      repeat ($urandom_range(0, W + 4)) @(negedge clk);
    end
    wait_until(k0 + W + 4);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_multiplier
`default_nettype wire
